slide_tick_gen: RTL and testbench
=================================

# slide_tick_gen

Parametrised, runtime-programmable tick and position generator for the sliding-text display path. It divides `clk` by a limit that can be reloaded while running, and can be paused and single-stepped. Each tick also advances or retreats a wrapping slide position, so the scroller can consume `pos` directly. It replaces the fixed-rate slide divider: same one-cycle tick semantics, with speed, direction and stepping control added.

## Interface
- `CNT_W`, 25, width of the divide counter and of `limit_in`.
- `DEFAULT_LIMIT`, 16666666, divide ratio loaded at reset (must fit in `CNT_W`).
- `POS_W`, 5, width of `pos`.
- `POS_MAX`, 15, last valid position; `pos` wraps between 0 and `POS_MAX` (must be < 2^`POS_W`).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  1 = run, 0 = pause.
- `dir`  in  1  0 = `pos` increments on tick, 1 = `pos` decrements.
- `limit_in`  in  `CNT_W`  new divide ratio.
- `limit_load`  in  1  single-cycle request to adopt `limit_in`.
- `step`  in  1  single-cycle request for one tick while paused.
- `tick`  out  1  one-cycle pulse per period.
- `pos`  out  `POS_W`  current slide position.
- `wrap`  out  1  one-cycle pulse, coincident with the `tick` that wrapped `pos`.
- `limit_pend`  out  1  a loaded limit is waiting for the next tick boundary.

## Operation
- Registers: `count` (`CNT_W`), `active_lim`, `shadow_lim`, `pos`, `tick`, `wrap`, `limit_pend`.
- Reset (`rst`=0, asynchronous) sets:
  - `count`=0, `active_lim`=`DEFAULT_LIMIT`, `shadow_lim`=0.
  - `tick`=0, `wrap`=0, `pos`=0, `limit_pend`=0.
  - FSM state = RUN.
- Effective limit L = max(`active_lim`, 1); a programmed 0 behaves as 1, i.e. a tick every cycle.
- FSM state RUN (`en`=1):
  - Each cycle `count` increments.
  - When `count`==L-1, `count`←0 and a tick event occurs.
  - `step` is ignored.
- FSM state PAUSED (`en`=0):
  - `count` holds and no ticks occur.
  - A `step` pulse causes exactly one tick event on that edge and clears `count`.
- Transitions:
  - RUN→PAUSED when `en`=0 is sampled; a tick due on that same edge is suppressed.
  - PAUSED→RUN when `en`=1 is sampled; counting resumes from the held `count`.
- Tick event (registered; all updates on the same edge):
  - `tick`←1.
  - `pos` moves by ±1 per `dir`. Forward: `POS_MAX`→0 sets `wrap`←1. Reverse: 0→`POS_MAX` sets `wrap`←1.
  - If `limit_pend`=1: `active_lim`←`shadow_lim`, `limit_pend`←0.
  - `tick` and `wrap` are 0 in every cycle without a tick event.
- Limit load:
  - `limit_load` in RUN: `shadow_lim`←`limit_in`, `limit_pend`←1; takes effect at the next tick boundary.
  - Repeated loads before that boundary: the last one wins.
  - `limit_load` on the same edge as a tick event: `active_lim`←`limit_in` directly, `limit_pend`←0. The new ratio governs the very next period.
  - `limit_load` in PAUSED: `active_lim`←`limit_in` and `count`←0 immediately; `limit_pend`←0.
  - `limit_load` and `step` together while PAUSED: the tick is issued and the new limit is adopted, both on that edge.
- `dir` is sampled only on tick edges; changing it between ticks has no other effect.
- `pos` never leaves 0..`POS_MAX`.

## Timing
- Release reset with `en`=1 (cycle 1 = first rising edge with `rst`=1). First `tick` is high during the cycle following edge L; then every L cycles.
- `pos`/`wrap` become visible in the same cycle as their `tick`.
- `step` at edge k (PAUSED) → `tick` high in the cycle after edge k.
- Reset asserted mid-period: all outputs return to reset values immediately (asynchronous); any pending limit is discarded.
- Latency from `limit_load` to the new period in RUN: up to one remaining old period.

## Test plan
- `DEFAULT_LIMIT`=4, `POS_MAX`=3, `en`=1, `dir`=0 for 20 cycles → `tick` every 4 cycles; `pos` 1,2,3,0,1; `wrap` only with the 4th tick.
- `dir`=1 from reset → `pos` 3,2,1,0 on successive ticks; `wrap` on the first tick (0→3).
- While running with L=4, load 2 mid-period → `limit_pend`=1; the current period still ends at 4 cycles; subsequent ticks every 2 cycles; `limit_pend`=0 at that boundary.
- `en`=0 after 2 counts, then 3 `step` pulses spaced 5 cycles apart → exactly 3 ticks, `pos` +3. Then `en`=1 → next tick 4 cycles later (`count` cleared by the last step).
- Load `limit_in`=0 → tick every cycle; then load 1 → still every cycle; then load 3 → every 3 cycles.
- Pull `rst` low mid-period with a load pending → `tick`/`wrap`/`pos`/`limit_pend` read 0 at once; after release, period = `DEFAULT_LIMIT`.

Source files
------------

// File: rtl/slide_tick_if.sv
// Control and status bundle between the slide tick generator and its user.
// Handshake: en is a level (run/pause); limit_load and step are single-cycle
// request pulses sampled on the rising clock edge, with no ready/acknowledge;
// tick and wrap are single-cycle pulses, and limit_pend is a level.
interface slide_tick_if #(
  parameter int CNT_W = 25,
  parameter int POS_W = 5
);
  logic             en;
  logic             dir;
  logic [CNT_W-1:0] limit_in;
  logic             limit_load;
  logic             step;
  logic             tick;
  logic [POS_W-1:0] pos;
  logic             wrap;
  logic             limit_pend;

  modport master (
    output en, dir, limit_in, limit_load, step,
    input  tick, pos, wrap, limit_pend
  );

  modport slave (
    input  en, dir, limit_in, limit_load, step,
    output tick, pos, wrap, limit_pend
  );
endinterface

// File: rtl/slide_tick_gen.sv
// Runtime-programmable tick divider with pause/step control and a wrapping
// slide position. A new limit loaded while running waits in a shadow
// register until the next tick boundary, so the current period is never cut.
module slide_tick_gen #(
  parameter int CNT_W         = 25,
  parameter int DEFAULT_LIMIT = 16666666,
  parameter int POS_W         = 5,
  parameter int POS_MAX       = 15
) (
  input  logic        clk,
  input  logic        rst,
  slide_tick_if.slave bus,
  output logic        fsm_state
);

  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LIM_RST  = CNT_W'(DEFAULT_LIMIT);
  localparam logic [CNT_W-1:0] LIM_ONE  = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [CNT_W-1:0] active_lim, active_n;
  logic [CNT_W-1:0] shadow_lim, shadow_n;
  logic [POS_W-1:0] pos_q, pos_n;
  logic             tick_q, tick_n;
  logic             wrap_q, wrap_n;
  logic             pend_q, pend_n;
  logic             tick_ev;
  logic [CNT_W-1:0] eff_lim;
  logic [CNT_W-1:0] last_cnt;

  // A programmed limit of 0 behaves as 1 (tick every cycle).
  assign eff_lim  = (active_lim == '0) ? LIM_ONE : active_lim;
  assign last_cnt = eff_lim - LIM_ONE;

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      count      <= '0;
      active_lim <= LIM_RST;
      shadow_lim <= '0;
      pos_q      <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      active_lim <= active_n;
      shadow_lim <= shadow_n;
      pos_q      <= pos_n;
      tick_q     <= tick_n;
      wrap_q     <= wrap_n;
      pend_q     <= pend_n;
    end
  end

  // Next state: en decides the behaviour of this edge, so a tick that would
  // fall on the edge where en drops is suppressed, and resuming counts at once.
  always_comb begin
    state_n  = bus.en ? RUN : PAUSED;
    count_n  = count;
    active_n = active_lim;
    shadow_n = shadow_lim;
    pos_n    = pos_q;
    tick_n   = 1'b0;
    wrap_n   = 1'b0;
    pend_n   = pend_q;
    tick_ev  = 1'b0;

    case (state_n)
      RUN: begin
        if (count == last_cnt) begin
          count_n = '0;
          tick_ev = 1'b1;
        end else begin
          count_n = count + LIM_ONE;
        end
      end
      PAUSED: begin
        if (bus.step || bus.limit_load) count_n = '0;
        tick_ev = bus.step;
      end
      default: ;
    endcase

    // A load adopts immediately on a tick edge or while paused; otherwise it
    // parks in the shadow register (last load wins) until the next boundary.
    if (bus.limit_load) begin
      shadow_n = bus.limit_in;
      if (tick_ev || state_n == PAUSED) begin
        active_n = bus.limit_in;
        pend_n   = 1'b0;
      end else begin
        pend_n   = 1'b1;
      end
    end else if (tick_ev && pend_q) begin
      active_n = shadow_lim;
      pend_n   = 1'b0;
    end

    // Position moves only on tick edges; dir is not looked at otherwise.
    if (tick_ev) begin
      tick_n = 1'b1;
      if (bus.dir) begin
        if (pos_q == '0) begin
          pos_n  = POS_LAST;
          wrap_n = 1'b1;
        end else begin
          pos_n  = pos_q - POS_ONE;
        end
      end else begin
        if (pos_q >= POS_LAST) begin
          pos_n  = '0;
          wrap_n = 1'b1;
        end else begin
          pos_n  = pos_q + POS_ONE;
        end
      end
    end
  end

  assign bus.tick       = tick_q;
  assign bus.pos        = pos_q;
  assign bus.wrap       = wrap_q;
  assign bus.limit_pend = pend_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_slide_tick_gen.sv
// Bench for slide_tick_gen: directed scenarios followed by a randomized run,
// each cycle compared against a period/position model of the generator.
module tb_slide_tick_gen;
  localparam int CNT_W         = 8;
  localparam int DEFAULT_LIMIT = 4;
  localparam int POS_W         = 5;
  localparam int POS_MAX       = 3;
  localparam int EXP_W         = POS_W + 4;

  logic clk;
  logic rst;
  logic fsm_state;

  slide_tick_if #(.CNT_W(CNT_W), .POS_W(POS_W)) bus ();

  slide_tick_gen #(
    .CNT_W(CNT_W), .DEFAULT_LIMIT(DEFAULT_LIMIT),
    .POS_W(POS_W), .POS_MAX(POS_MAX)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .fsm_state(fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {paused, tick, wrap, limit_pend, pos}, one entry per clock edge.
  logic [EXP_W-1:0] exp_q[$];

  // Model: elapsed cycles in the current period, the period in force,
  // a parked limit, and the position as a plain integer.
  int m_elapsed, m_lim, m_shadow, m_pend, m_pos;

  task automatic model_reset();
    m_elapsed = 0; m_lim = DEFAULT_LIMIT; m_shadow = 0; m_pend = 0; m_pos = 0;
  endtask

  task automatic model_edge(input bit e, input bit d, input bit ld,
                            input int li, input bit st);
    int period;
    bit t, w;
    logic [EXP_W-1:0] ex;
    period = (m_lim == 0) ? 1 : m_lim;
    t = 1'b0;
    w = 1'b0;
    if (e) begin
      m_elapsed++;
      if (m_elapsed >= period) begin
        t = 1'b1;
        m_elapsed = 0;
      end
    end else begin
      if (st) t = 1'b1;
      if (st || ld) m_elapsed = 0;
    end
    if (ld) begin
      if (t || !e) begin m_lim = li; m_pend = 0; end
      else begin m_shadow = li; m_pend = 1; end
    end else if (t && m_pend == 1) begin
      m_lim = m_shadow; m_pend = 0;
    end
    if (t) begin
      m_pos = (m_pos + (d ? -1 : 1) + POS_MAX + 1) % (POS_MAX + 1);
      w = d ? (m_pos == POS_MAX) : (m_pos == 0);
    end
    ex = {~e, t, w, (m_pend == 1), POS_W'(m_pos)};
    exp_q.push_back(ex);
  endtask

  function automatic logic [EXP_W-1:0] observed();
    return {fsm_state, bus.tick, bus.wrap, bus.limit_pend, bus.pos};
  endfunction

  task automatic check(input string tag, input logic [EXP_W-1:0] ex);
    logic [EXP_W-1:0] ob;
    ob = observed();
    n_tests++;
    assert (ob === ex) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed {st,tick,wrap,pend,pos}=%b required %b",
             tag, $time, ob, ex);
    end
  endtask

  // Driver: present inputs for one edge, advance the model, compare after it.
  task automatic cyc(input string tag, input bit e, input bit d, input bit ld,
                     input int li, input bit st);
    logic [EXP_W-1:0] ex;
    bus.en = e; bus.dir = d; bus.limit_load = ld;
    bus.limit_in = CNT_W'(li); bus.step = st;
    model_edge(e, d, ld, li, st);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %b required an entry", tag, observed());
    end else begin
      ex = exp_q.pop_front();
      check(tag, ex);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.en = 1'b1; bus.dir = 1'b0; bus.limit_load = 1'b0;
    bus.limit_in = '0; bus.step = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", '0);
    rst = 1'b1;
  endtask

  initial begin
    bus.en = 1'b1; bus.dir = 1'b0; bus.limit_load = 1'b0;
    bus.limit_in = '0; bus.step = 1'b0;
    rst = 1'b0;

    // Forward run at the default period.
    do_reset();
    for (int i = 0; i < 20; i++) cyc("fwd_default", 1, 0, 0, 0, 0);

    // Reverse run from reset: first tick wraps 0 -> POS_MAX.
    do_reset();
    for (int i = 0; i < 16; i++) cyc("rev_default", 1, 1, 0, 0, 0);

    // Load 2 mid-period: pending until the boundary, then period 2.
    do_reset();
    cyc("load_mid", 1, 0, 0, 0, 0);
    cyc("load_mid", 1, 0, 1, 2, 0);
    for (int i = 0; i < 10; i++) cyc("load_mid", 1, 0, 0, 0, 0);

    // Pause after two counts, three spaced steps, then resume.
    do_reset();
    cyc("pause", 1, 0, 0, 0, 0);
    cyc("pause", 1, 0, 0, 0, 0);
    for (int s = 0; s < 3; s++) begin
      cyc("step", 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc("step_gap", 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 9; i++) cyc("resume", 1, 0, 0, 0, 0);

    // Limits 0, 1, then 3.
    do_reset();
    cyc("lim0", 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc("lim0", 1, 0, 0, 0, 0);
    cyc("lim1", 1, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc("lim1", 1, 0, 0, 0, 0);
    cyc("lim3", 1, 0, 1, 3, 0);
    for (int i = 0; i < 10; i++) cyc("lim3", 1, 0, 0, 0, 0);

    // Paused load together with a step, and a paused load alone.
    cyc("pload", 0, 0, 1, 5, 1);
    cyc("pload", 0, 0, 1, 2, 0);
    for (int i = 0; i < 6; i++) cyc("pload_run", 1, 1, 0, 0, 0);

    // Asynchronous reset mid-period with a load pending.
    cyc("async_rst", 1, 0, 1, 6, 0);
    cyc("async_rst", 1, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    check("async_rst_now", '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) cyc("after_rst", 1, 0, 0, 0, 0);

    // Randomized control traffic.
    begin
      bit d = 1'b0;
      for (int i = 0; i < 400; i++) begin
        bit e, ld, st;
        int li;
        e  = ($urandom_range(0, 7) != 0);
        ld = ($urandom_range(0, 9) == 0);
        st = ($urandom_range(0, 3) == 0);
        li = $urandom_range(0, 5);
        if ($urandom_range(0, 5) == 0) d = ~d;
        cyc("random", e, d, ld, li, st);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running required done");
    $fatal(1, "timeout");
  end
endmodule
